// File: rtl/fsm_sar_mc_if.sv
// Control, analog-front-end and result handshake bundle for fsm_sar_mc.
// master = conversion controller, slave = environment driving start/cmp/ready.
interface fsm_sar_mc_if #(
    parameter int Width    = 8,
    parameter int Channels = 4
);
    localparam int ChW = (Channels > 1) ? $clog2(Channels) : 1;

    logic             start_i;
    logic             scan_i;
    logic [ChW-1:0]   chan_i;
    logic             abort_i;
    logic             cmp_i;
    logic [ChW-1:0]   chan_o;
    logic             sample_o;
    logic [Width-1:0] dac_o;
    logic [Width-1:0] result_o;
    logic [ChW-1:0]   result_chan_o;
    logic             valid_o;
    logic             ready_i;
    logic             eoc_o;
    logic             busy_o;

    modport master (
        input  start_i, scan_i, chan_i, abort_i, cmp_i, ready_i,
        output chan_o, sample_o, dac_o, result_o, result_chan_o,
        output valid_o, eoc_o, busy_o
    );

    modport slave (
        output start_i, scan_i, chan_i, abort_i, cmp_i, ready_i,
        input  chan_o, sample_o, dac_o, result_o, result_chan_o,
        input  valid_o, eoc_o, busy_o
    );
endinterface

// File: rtl/fsm_sar_mc.sv
// Multi-channel SAR ADC conversion controller with scan mode
// and a stalling valid/ready result port.
module fsm_sar_mc #(
    parameter int Width        = 8,
    parameter int Channels     = 4,
    parameter int SampleCycles = 2
) (
    input logic          clk_i,
    input logic          rst_ni,
    fsm_sar_mc_if.master bus
);
    localparam int ChW  = (Channels > 1) ? $clog2(Channels) : 1;
    localparam int CntW = (SampleCycles > 1) ? $clog2(SampleCycles) : 1;
    localparam logic [ChW-1:0]   LastCh  = ChW'(Channels - 1);
    localparam logic [CntW-1:0]  LastCnt = CntW'(SampleCycles - 1);
    localparam logic [Width-1:0] Msb     = {1'b1, {(Width-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, SAMPLE, CONV, OUT} state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_scan;
    logic [CntW-1:0]  r_cnt;
    logic [Width-1:0] r_dac;
    logic [Width-1:0] r_mask;
    logic [Width-1:0] r_result;
    logic [ChW-1:0]   r_chan;
    logic [ChW-1:0]   r_rchan;
    logic             r_valid;
    logic             r_eoc;

    logic             w_abort;
    logic             w_load;
    logic             w_more;
    logic [ChW-1:0]   w_chan_sel;
    logic [Width-1:0] w_dac_next;

    assign w_abort    = bus.abort_i && (r_state != IDLE);
    assign w_load     = (r_state == OUT) && !bus.abort_i
                        && (!r_valid || bus.ready_i);
    assign w_more     = r_scan && (r_chan < LastCh);
    assign w_chan_sel = (bus.chan_i > LastCh) ? LastCh : bus.chan_i;
    // r_mask marks the bit under trial; drop it on a low compare, arm the next
    assign w_dac_next = (bus.cmp_i ? r_dac : (r_dac & ~r_mask))
                        | (r_mask >> 1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = IDLE;
        end else begin
            unique case (r_state)
                IDLE:    if (bus.start_i)      w_next = SAMPLE;
                SAMPLE:  if (r_cnt == LastCnt) w_next = CONV;
                CONV:    if (r_mask[0])        w_next = OUT;
                OUT:     if (w_load) w_next = w_more ? SAMPLE : IDLE;
                default: w_next = IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy_o        = (r_state != IDLE);
        bus.sample_o      = (r_state == SAMPLE);
        bus.chan_o        = r_chan;
        bus.dac_o         = r_dac;
        bus.result_o      = r_result;
        bus.result_chan_o = r_rchan;
        bus.valid_o       = r_valid;
        bus.eoc_o         = r_eoc;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_scan   <= 1'b0;
            r_cnt    <= '0;
            r_dac    <= '0;
            r_mask   <= '0;
            r_result <= '0;
            r_chan   <= '0;
            r_rchan  <= '0;
            r_valid  <= 1'b0;
            r_eoc    <= 1'b0;
        end else begin
            r_eoc <= 1'b0;
            // handshake runs independently of the FSM so abort never drops a result
            if (w_load) begin
                r_result <= r_dac;
                r_rchan  <= r_chan;
                r_valid  <= 1'b1;
            end else if (bus.ready_i) begin
                r_valid  <= 1'b0;
            end
            if (w_abort) begin
                r_dac  <= '0;
                r_mask <= '0;
            end else begin
                unique case (r_state)
                    IDLE: begin
                        if (bus.start_i) begin
                            r_scan <= bus.scan_i;
                            r_chan <= bus.scan_i ? '0 : w_chan_sel;
                            r_cnt  <= '0;
                        end
                    end
                    SAMPLE: begin
                        if (r_cnt == LastCnt) begin
                            r_dac  <= Msb;
                            r_mask <= Msb;
                        end else begin
                            r_cnt  <= r_cnt + 1'b1;
                        end
                    end
                    CONV: begin
                        r_dac  <= w_dac_next;
                        r_mask <= r_mask >> 1;
                    end
                    OUT: begin
                        if (w_load) begin
                            r_dac <= '0;
                            if (w_more) begin
                                r_chan <= r_chan + 1'b1;
                                r_cnt  <= '0;
                            end else begin
                                r_eoc  <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fsm_sar_mc.sv
// Bench for fsm_sar_mc: directed and randomized conversions against
// an ideal binary-search model, on three parameter sets.
module tb_fsm_sar_mc;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    fsm_sar_mc_if #(.Width(8),  .Channels(4)) b0 ();
    fsm_sar_mc_if #(.Width(4),  .Channels(6)) b1 ();
    fsm_sar_mc_if #(.Width(12), .Channels(1)) b2 ();

    fsm_sar_mc #(.Width(8), .Channels(4), .SampleCycles(2)) u0 (
        .clk_i(clk), .rst_ni(rst_n), .bus(b0.master));
    fsm_sar_mc #(.Width(4), .Channels(6), .SampleCycles(1)) u1 (
        .clk_i(clk), .rst_ni(rst_n), .bus(b1.master));
    fsm_sar_mc #(.Width(12), .Channels(1), .SampleCycles(5)) u2 (
        .clk_i(clk), .rst_ni(rst_n), .bus(b2.master));

    // ideal comparators: analog input per channel vs DAC code
    logic [7:0]  vin0 [4];
    logic [3:0]  vin1 [8];
    logic [11:0] vin2;
    assign b0.cmp_i = (vin0[b0.chan_o] >= b0.dac_o);
    assign b1.cmp_i = (vin1[b1.chan_o] >= b1.dac_o);
    assign b2.cmp_i = (vin2 >= b2.dac_o);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // k-th trial of a binary search: decided top bits of v, then a 1
    function automatic int trial(int v, int w, int k);
        int hi;
        hi = (v >> (w - k)) << (w - k);
        return hi | (1 << (w - 1 - k));
    endfunction

    initial begin
        int n;
        int ch_in;
        int exp_ch;
        logic exp_v;

        {b0.start_i, b0.scan_i, b0.chan_i, b0.abort_i, b0.ready_i} = '0;
        {b1.start_i, b1.scan_i, b1.chan_i, b1.abort_i, b1.ready_i} = '0;
        {b2.start_i, b2.scan_i, b2.chan_i, b2.abort_i, b2.ready_i} = '0;
        for (int i = 0; i < 4; i++) vin0[i] = '0;
        for (int i = 0; i < 8; i++) vin1[i] = '0;
        vin2 = '0;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_valid", b0.valid_o, 0);
        chk("rst_busy", b0.busy_o, 0);
        chk("rst_dac", b0.dac_o, 0);
        chk("rst_sample", b0.sample_o, 0);
        chk("rst_eoc", b0.eoc_o, 0);
        chk("rst_result", b0.result_o, 0);
        chk("rst_chan", b0.chan_o, 0);
        chk("rst_busy1", b1.busy_o, 0);
        chk("rst_valid2", b2.valid_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // single conversion on channel 2, with a stray start while busy
        vin0[2] = 8'hA5;
        b0.ready_i = 1'b1;
        b0.chan_i = 2'd2;
        b0.scan_i = 1'b0;
        b0.start_i = 1'b1;
        tick();
        b0.start_i = 1'b0;
        chk("s_chan", b0.chan_o, 2);
        chk("s_sample0", b0.sample_o, 1);
        chk("s_busy", b0.busy_o, 1);
        chk("s_dac0", b0.dac_o, 0);
        tick();
        chk("s_sample1", b0.sample_o, 1);
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("s_trial", b0.dac_o, trial(8'hA5, 8, k));
            chk("s_sample_off", b0.sample_o, 0);
            b0.start_i = (k == 3);
            b0.scan_i  = (k == 3);
            b0.chan_i  = 2'd1;
        end
        b0.start_i = 1'b0;
        b0.scan_i  = 1'b0;
        tick();
        chk("s_valid_early", b0.valid_o, 0);
        chk("s_final_code", b0.dac_o, 8'hA5);
        tick();
        chk("s_valid", b0.valid_o, 1);
        chk("s_result", b0.result_o, 8'hA5);
        chk("s_rchan", b0.result_chan_o, 2);
        chk("s_eoc", b0.eoc_o, 1);
        chk("s_busy_end", b0.busy_o, 0);
        chk("s_dac_end", b0.dac_o, 0);
        tick();
        chk("s_eoc_pulse", b0.eoc_o, 0);
        chk("s_valid_clr", b0.valid_o, 0);
        chk("s_no_restart", b0.busy_o, 0);

        // scan, consumer always ready
        vin0[0] = 8'h00;
        vin0[1] = 8'hFF;
        vin0[2] = 8'h80;
        vin0[3] = 8'h3C;
        b0.scan_i = 1'b1;
        b0.chan_i = 2'd0;
        b0.start_i = 1'b1;
        tick();
        b0.start_i = 1'b0;
        for (int e = 1; e <= 47; e++) begin
            tick();
            exp_v = (e % 11 == 0) && (e <= 44);
            chk("sc_valid", b0.valid_o, exp_v);
            chk("sc_eoc", b0.eoc_o, exp_v && (e == 44));
            chk("sc_busy", b0.busy_o, e < 44);
            if (exp_v) begin
                chk("sc_result", b0.result_o, vin0[e / 11 - 1]);
                chk("sc_rchan", b0.result_chan_o, e / 11 - 1);
            end
        end

        // scan with backpressure, then abort mid-conversion of ch2
        b0.ready_i = 1'b0;
        b0.start_i = 1'b1;
        tick();
        b0.start_i = 1'b0;
        for (int e = 1; e <= 30; e++) begin
            tick();
            chk("bp_valid", b0.valid_o, e >= 11);
            chk("bp_busy", b0.busy_o, 1);
            chk("bp_eoc", b0.eoc_o, 0);
            if (e >= 11) begin
                chk("bp_hold_res", b0.result_o, 8'h00);
                chk("bp_hold_ch", b0.result_chan_o, 0);
            end
        end
        chk("bp_stall_dac", b0.dac_o, 8'hFF);
        chk("bp_stall_chan", b0.chan_o, 1);
        chk("bp_stall_smp", b0.sample_o, 0);
        b0.ready_i = 1'b1;
        tick();
        b0.ready_i = 1'b0;
        chk("bp_load_valid", b0.valid_o, 1);
        chk("bp_load_res", b0.result_o, 8'hFF);
        chk("bp_load_ch", b0.result_chan_o, 1);
        repeat (5) tick();
        chk("ab_pre_dac", b0.dac_o, trial(8'h80, 8, 3));
        chk("ab_pre_chan", b0.chan_o, 2);
        b0.abort_i = 1'b1;
        tick();
        b0.abort_i = 1'b0;
        chk("ab_busy", b0.busy_o, 0);
        chk("ab_dac", b0.dac_o, 0);
        chk("ab_sample", b0.sample_o, 0);
        for (int e = 0; e < 3; e++) begin
            chk("ab_eoc", b0.eoc_o, 0);
            chk("ab_valid", b0.valid_o, 1);
            chk("ab_res", b0.result_o, 8'hFF);
            chk("ab_ch", b0.result_chan_o, 1);
            chk("ab_idle", b0.busy_o, 0);
            tick();
        end
        b0.ready_i = 1'b1;
        tick();
        chk("ab_drain", b0.valid_o, 0);

        // Width=4, Channels=6, SampleCycles=1: clamp and random inputs
        b1.ready_i = 1'b1;
        for (int t = 0; t < 10; t++) begin
            ch_in = (t == 0) ? 5 : (t == 1) ? 7 : int'($urandom_range(0, 7));
            exp_ch = (ch_in > 5) ? 5 : ch_in;
            vin1[exp_ch] = 4'($urandom_range(0, 15));
            b1.chan_i = 3'(ch_in);
            b1.start_i = 1'b1;
            tick();
            b1.start_i = 1'b0;
            chk("p1_chan", b1.chan_o, exp_ch);
            n = 0;
            while (!b1.valid_o && n < 100) begin
                tick();
                n++;
            end
            chk("p1_latency", n, 1 + 4 + 1);
            chk("p1_result", b1.result_o, vin1[exp_ch]);
            chk("p1_rchan", b1.result_chan_o, exp_ch);
            chk("p1_eoc", b1.eoc_o, 1);
            tick();
        end

        // Width=12, Channels=1, SampleCycles=5: scan behaves as single
        b2.ready_i = 1'b1;
        for (int t = 0; t < 6; t++) begin
            vin2 = (t == 0) ? 12'h000 : (t == 1) ? 12'hFFF
                 : 12'($urandom_range(0, 4095));
            b2.scan_i = 1'($urandom_range(0, 1));
            b2.chan_i = 1'($urandom_range(0, 1));
            b2.start_i = 1'b1;
            tick();
            b2.start_i = 1'b0;
            chk("p2_chan", b2.chan_o, 0);
            n = 0;
            while (!b2.valid_o && n < 100) begin
                tick();
                n++;
            end
            chk("p2_latency", n, 5 + 12 + 1);
            chk("p2_result", b2.result_o, vin2);
            chk("p2_rchan", b2.result_chan_o, 0);
            chk("p2_eoc", b2.eoc_o, 1);
            tick();
            chk("p2_idle", b2.busy_o, 0);
        end

        // asynchronous reset mid-conversion with a result pending
        b0.ready_i = 1'b0;
        b0.scan_i = 1'b0;
        b0.chan_i = 2'd3;
        b0.start_i = 1'b1;
        tick();
        b0.start_i = 1'b0;
        n = 0;
        while (!b0.valid_o && n < 100) begin
            tick();
            n++;
        end
        chk("r_pending", b0.result_o, 8'h3C);
        b0.start_i = 1'b1;
        tick();
        b0.start_i = 1'b0;
        repeat (5) tick();
        chk("r_in_conv", b0.busy_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("r_valid", b0.valid_o, 0);
        chk("r_busy", b0.busy_o, 0);
        chk("r_dac", b0.dac_o, 0);
        chk("r_result", b0.result_o, 0);
        chk("r_rchan", b0.result_chan_o, 0);
        chk("r_chan", b0.chan_o, 0);
        chk("r_sample", b0.sample_o, 0);
        chk("r_eoc", b0.eoc_o, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
